// File: rtl/fetch_stage_controller.sv
// -----------------------------------------------------------------------------
// fetch_stage_controller
//
// Sequences the instruction-fetch stage. From the branch resolution (EX/MEM),
// the ID-stage load-use hazard and halt/resume requests it generates the
// program-counter load enable, the PC mux select and the IF/ID register
// load/flush controls. It also provides a boot delay after reset, a watchdog
// that breaks out of overlong stalls, and fetch/stall performance counters.
//
// Parameters
//   BOOT_CYCLES   cycles spent in BOOT after reset release (>= 1)
//   STALL_CYCLES  frozen cycles per load-use hazard pulse (>= 1)
//   MAX_STALL     consecutive frozen cycles before the watchdog forces RUN (>= 2)
//
// Ports
//   clk_i             rising-edge clock
//   reset_i           synchronous active-high reset
//   branch_taken_i    branch resolved taken in EX/MEM (PCSrc)
//   load_use_i        ID-stage load-use hazard
//   halt_req_i        request to stop fetching
//   resume_i          leave HALT
//   pc_write_en_o     program counter load enable
//   pc_sel_o          1 = branch target, 0 = PC+4
//   if_id_write_en_o  IF/ID register load enable
//   if_id_flush_o     IF/ID loads a bubble; overrides if_id_write_en_o
//   fetch_active_o    state is RUN
//   state_o           BOOT=0, RUN=1, STALL=2, HALT=3
//   stall_timeout_o   sticky watchdog flag
//   fetch_count_o     sequential fetch cycles (pc_write_en=1, pc_sel=0); wraps
//   stall_count_o     total frozen cycles; saturates at 16'hFFFF
//
// Control outputs are combinational from state and inputs; every other output
// comes straight from a register.
// -----------------------------------------------------------------------------
module fetch_stage_controller #(
  parameter int BOOT_CYCLES  = 2,
  parameter int STALL_CYCLES = 1,
  parameter int MAX_STALL    = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        branch_taken_i,
  input  logic        load_use_i,
  input  logic        halt_req_i,
  input  logic        resume_i,
  output logic        pc_write_en_o,
  output logic        pc_sel_o,
  output logic        if_id_write_en_o,
  output logic        if_id_flush_o,
  output logic        fetch_active_o,
  output logic [1:0]  state_o,
  output logic        stall_timeout_o,
  output logic [31:0] fetch_count_o,
  output logic [15:0] stall_count_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam int WW = $clog2(MAX_STALL + 1);

  localparam logic [BW-1:0] BOOT_LAST    = BW'(BOOT_CYCLES - 1);
  localparam logic [BW-1:0] BOOT_ONE     = BW'(1);
  localparam logic [SW-1:0] STALL_RELOAD = SW'(STALL_CYCLES - 1);
  localparam logic [SW-1:0] STALL_ONE    = SW'(1);
  localparam logic [WW-1:0] WDOG_LAST    = WW'(MAX_STALL - 1);
  localparam logic [WW-1:0] WDOG_ONE     = WW'(1);

  state_e        state_q, state_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          halt_pending_q, halt_pending_d;
  logic          wdog_force_q, wdog_force_d;
  logic          stall_timeout_q, stall_timeout_d;
  logic [31:0]   fetch_count_q;
  logic [15:0]   stall_count_q;

  logic          pc_write_en_s;
  logic          pc_sel_s;
  logic          if_id_write_en_s;
  logic          if_id_flush_s;
  logic          frozen_s;
  logic          fetch_inc_s;

  // Next-state, control-output and watchdog decision logic.
  always_comb begin
    state_d          = state_q;
    boot_cnt_d       = boot_cnt_q;
    stall_cnt_d      = stall_cnt_q;
    wdog_cnt_d       = wdog_cnt_q;
    halt_pending_d   = halt_pending_q;
    wdog_force_d     = 1'b0;
    stall_timeout_d  = stall_timeout_q;
    pc_write_en_s    = 1'b0;
    pc_sel_s         = 1'b0;
    if_id_write_en_s = 1'b0;
    if_id_flush_s    = 1'b0;
    frozen_s         = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // Keep a bubble in IF/ID until the boot delay has elapsed.
        if_id_flush_s = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_ONE;
        end
      end

      ST_RUN, ST_STALL: begin
        if (branch_taken_i) begin
          // Redirect: load branch target and squash the wrong-path fetch.
          // A simultaneous or already pending halt still takes effect.
          pc_write_en_s    = 1'b1;
          pc_sel_s         = 1'b1;
          if_id_write_en_s = 1'b1;
          if_id_flush_s    = 1'b1;
          stall_cnt_d      = '0;
          halt_pending_d   = 1'b0;
          if (halt_req_i || halt_pending_q) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_RUN) begin
          if (halt_req_i || halt_pending_q) begin
            // The current fetch completes normally; fetching stops next cycle.
            pc_write_en_s    = 1'b1;
            if_id_write_en_s = 1'b1;
            state_d          = ST_HALT;
            halt_pending_d   = 1'b0;
          end else if (load_use_i && !wdog_force_q) begin
            // First frozen cycle of a hazard; single-cycle stalls never leave RUN.
            frozen_s = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d     = ST_STALL;
              stall_cnt_d = STALL_RELOAD;
            end else begin
              state_d     = ST_RUN;
              stall_cnt_d = '0;
            end
          end else begin
            pc_write_en_s    = 1'b1;
            if_id_write_en_s = 1'b1;
          end
        end else begin
          // STALL: frozen; a halt request is remembered until the stall ends.
          frozen_s = 1'b1;
          if (load_use_i) begin
            stall_cnt_d    = STALL_RELOAD;
            halt_pending_d = halt_pending_q | halt_req_i;
          end else if (stall_cnt_q == STALL_ONE) begin
            stall_cnt_d    = '0;
            halt_pending_d = 1'b0;
            if (halt_pending_q || halt_req_i) begin
              state_d = ST_HALT;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            stall_cnt_d    = stall_cnt_q - STALL_ONE;
            halt_pending_d = halt_pending_q | halt_req_i;
          end
        end
      end

      ST_HALT: begin
        if_id_flush_s = 1'b1;
        if (resume_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Watchdog: the MAX_STALL-th consecutive frozen cycle forces RUN and the
    // following RUN cycle ignores load_use so at least one fetch gets through.
    // A halt requested during the stall is kept pending and honoured from RUN.
    if (frozen_s) begin
      if (wdog_cnt_q == WDOG_LAST) begin
        wdog_cnt_d      = '0;
        stall_timeout_d = 1'b1;
        wdog_force_d    = 1'b1;
        state_d         = ST_RUN;
        stall_cnt_d     = '0;
        halt_pending_d  = halt_pending_q | halt_req_i;
      end else begin
        wdog_cnt_d = wdog_cnt_q + WDOG_ONE;
      end
    end else begin
      wdog_cnt_d = '0;
    end
  end

  // Only sequential PC+4 loads are counted as fetches; redirects are not.
  assign fetch_inc_s = pc_write_en_s & ~pc_sel_s;

  // State, sequencing counters and performance counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_BOOT;
      boot_cnt_q      <= '0;
      stall_cnt_q     <= '0;
      wdog_cnt_q      <= '0;
      halt_pending_q  <= 1'b0;
      wdog_force_q    <= 1'b0;
      stall_timeout_q <= 1'b0;
      fetch_count_q   <= 32'd0;
      stall_count_q   <= 16'd0;
    end else begin
      state_q         <= state_d;
      boot_cnt_q      <= boot_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      wdog_cnt_q      <= wdog_cnt_d;
      halt_pending_q  <= halt_pending_d;
      wdog_force_q    <= wdog_force_d;
      stall_timeout_q <= stall_timeout_d;
      if (fetch_inc_s) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (frozen_s && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign pc_write_en_o    = pc_write_en_s;
  assign pc_sel_o         = pc_sel_s;
  assign if_id_write_en_o = if_id_write_en_s;
  assign if_id_flush_o    = if_id_flush_s;
  assign fetch_active_o   = (state_q == ST_RUN);
  assign state_o          = state_q;
  assign stall_timeout_o  = stall_timeout_q;
  assign fetch_count_o    = fetch_count_q;
  assign stall_count_o    = stall_count_q;

endmodule

// File: tb/tb_fetch_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage_controller
//
// Two instances share the stimulus: dut1 with single-cycle stalls and dut3
// with three-cycle stalls. A behavioural model tracks remaining boot cycles,
// remaining frozen cycles, halt status and the counters for each instance.
// A directed vector table, two hand-written sequences (watchdog, reset in
// mid-stall) and a randomized run are all checked against it.
// -----------------------------------------------------------------------------
module tb_fetch_stage_controller;

  localparam int BOOT = 2;
  localparam int MAXS = 16;

  logic clk = 1'b0;
  logic reset_s, br_s, lu_s, hr_s, rs_s;

  logic        d1_pwe, d1_sel, d1_ifwe, d1_fl, d1_act, d1_tmo;
  logic [1:0]  d1_st;
  logic [31:0] d1_fc;
  logic [15:0] d1_sc;
  logic        d3_pwe, d3_sel, d3_ifwe, d3_fl, d3_act, d3_tmo;
  logic [1:0]  d3_st;
  logic [31:0] d3_fc;
  logic [15:0] d3_sc;

  fetch_stage_controller #(.BOOT_CYCLES(BOOT), .STALL_CYCLES(1), .MAX_STALL(MAXS)) dut1 (
    .clk_i(clk), .reset_i(reset_s), .branch_taken_i(br_s), .load_use_i(lu_s),
    .halt_req_i(hr_s), .resume_i(rs_s),
    .pc_write_en_o(d1_pwe), .pc_sel_o(d1_sel), .if_id_write_en_o(d1_ifwe),
    .if_id_flush_o(d1_fl), .fetch_active_o(d1_act), .state_o(d1_st),
    .stall_timeout_o(d1_tmo), .fetch_count_o(d1_fc), .stall_count_o(d1_sc)
  );

  fetch_stage_controller #(.BOOT_CYCLES(BOOT), .STALL_CYCLES(3), .MAX_STALL(MAXS)) dut3 (
    .clk_i(clk), .reset_i(reset_s), .branch_taken_i(br_s), .load_use_i(lu_s),
    .halt_req_i(hr_s), .resume_i(rs_s),
    .pc_write_en_o(d3_pwe), .pc_sel_o(d3_sel), .if_id_write_en_o(d3_ifwe),
    .if_id_flush_o(d3_fl), .fetch_active_o(d3_act), .state_o(d3_st),
    .stall_timeout_o(d3_tmo), .fetch_count_o(d3_fc), .stall_count_o(d3_sc)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int        boot_left;    // boot cycles still to go
    int        freeze_left;  // further frozen cycles owed after this one
    int        frozen_run;   // consecutive frozen cycles so far
    bit        halted;
    bit        halt_pend;
    bit        force_go;     // this cycle must fetch regardless of load_use
    bit        timeout;
    bit [31:0] fetches;
    int        stalls;
  } mdl_t;

  typedef struct packed {
    logic        pwe, sel, ifwe, fl, act;
    logic [1:0]  st;
    logic        tmo;
    logic [31:0] fc;
    logic [15:0] sc;
  } exp_t;

  mdl_t m1, n1, m3, n3;
  exp_t e1, e3;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   burst  = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '0;
    r.boot_left = BOOT;
    return r;
  endfunction

  task automatic mdl_step(input mdl_t m, input int S, input logic r, b, l, h, q,
                          output mdl_t n, output exp_t e);
    bit frozen;
    n = m;
    e = '0;
    frozen = 1'b0;
    n.force_go = 1'b0;
    e.tmo = m.timeout;
    e.fc  = m.fetches;
    e.sc  = m.stalls[15:0];
    if (m.boot_left > 0) begin
      e.st = 2'd0; e.fl = 1'b1;
      n.boot_left = m.boot_left - 1;
    end else if (m.halted) begin
      e.st = 2'd3; e.fl = 1'b1;
      if (q) n.halted = 1'b0;
    end else begin
      e.st = (m.freeze_left > 0) ? 2'd2 : 2'd1;
      if (b) begin
        e.pwe = 1'b1; e.sel = 1'b1; e.ifwe = 1'b1; e.fl = 1'b1;
        n.freeze_left = 0;
        n.halted = h || m.halt_pend;
        n.halt_pend = 1'b0;
      end else if (m.freeze_left == 0) begin
        if (h || m.halt_pend) begin
          e.pwe = 1'b1; e.ifwe = 1'b1;
          n.halted = 1'b1; n.halt_pend = 1'b0;
        end else if (l && !m.force_go) begin
          frozen = 1'b1;
          n.freeze_left = S - 1;
        end else begin
          e.pwe = 1'b1; e.ifwe = 1'b1;
        end
      end else begin
        frozen = 1'b1;
        n.freeze_left = l ? (S - 1) : (m.freeze_left - 1);
        if (n.freeze_left == 0 && (m.halt_pend || h)) begin
          n.halted = 1'b1; n.halt_pend = 1'b0;
        end else begin
          n.halt_pend = m.halt_pend || h;
        end
      end
    end
    e.act = (e.st == 2'd1);
    if (frozen) begin
      if (m.stalls < 65535) n.stalls = m.stalls + 1;
      n.frozen_run = m.frozen_run + 1;
      if (n.frozen_run == MAXS) begin
        n.timeout = 1'b1; n.force_go = 1'b1; n.frozen_run = 0;
        n.freeze_left = 0; n.halted = 1'b0;
        n.halt_pend = m.halt_pend || h;
      end
    end else begin
      n.frozen_run = 0;
    end
    if (e.pwe && !e.sel) n.fetches = m.fetches + 32'd1;
    if (r) n = mdl_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string who, input exp_t e,
                     input logic pwe, sel, ifwe, fl, act, input logic [1:0] st,
                     input logic tmo, input logic [31:0] fc, input logic [15:0] sc);
    chk({who, ".pc_write_en"},    32'(pwe),  32'(e.pwe));
    chk({who, ".pc_sel"},         32'(sel),  32'(e.sel));
    chk({who, ".if_id_write_en"}, 32'(ifwe), 32'(e.ifwe));
    chk({who, ".if_id_flush"},    32'(fl),   32'(e.fl));
    chk({who, ".fetch_active"},   32'(act),  32'(e.act));
    chk({who, ".state"},          32'(st),   32'(e.st));
    chk({who, ".stall_timeout"},  32'(tmo),  32'(e.tmo));
    chk({who, ".fetch_count"},    fc,        e.fc);
    chk({who, ".stall_count"},    32'(sc),   32'(e.sc));
  endtask

  // Apply inputs just after a rising edge, then sample at the falling edge.
  task automatic drive(input logic r, b, l, h, q);
    reset_s = r; br_s = b; lu_s = l; hr_s = h; rs_s = q;
    @(negedge clk);
    mdl_step(m1, 1, r, b, l, h, q, n1, e1);
    mdl_step(m3, 3, r, b, l, h, q, n3, e3);
    cmp("dut1", e1, d1_pwe, d1_sel, d1_ifwe, d1_fl, d1_act, d1_st, d1_tmo, d1_fc, d1_sc);
    cmp("dut3", e3, d3_pwe, d3_sel, d3_ifwe, d3_fl, d3_act, d3_st, d3_tmo, d3_fc, d3_sc);
  endtask

  task automatic advance();
    m1 = n1;
    m3 = n3;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (expected values for dut1)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic r, b, l, h, q;
    logic pwe, sel, ifwe, fl;
    logic [1:0] st;
    logic [31:0] fc;
    logic [15:0] sc;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mkv(input logic r, b, l, h, q, pwe, sel, ifwe, fl,
                               input logic [1:0] st, input logic [31:0] fc,
                               input logic [15:0] sc);
    vec_t v;
    v.r = r; v.b = b; v.l = l; v.h = h; v.q = q;
    v.pwe = pwe; v.sel = sel; v.ifwe = ifwe; v.fl = fl;
    v.st = st; v.fc = fc; v.sc = sc;
    return v;
  endfunction

  initial begin
    //              r b l h q  pwe sel ifwe fl  st    fc     sc
    vecs[0]  = mkv(1,0,0,0,0, 0,0,0,1, 2'd0, 32'd0, 16'd0);  // reset held
    vecs[1]  = mkv(0,0,0,0,0, 0,0,0,1, 2'd0, 32'd0, 16'd0);  // boot 1
    vecs[2]  = mkv(0,0,0,0,0, 0,0,0,1, 2'd0, 32'd0, 16'd0);  // boot 2
    vecs[3]  = mkv(0,0,0,0,0, 1,0,1,0, 2'd1, 32'd0, 16'd0);  // first fetch
    vecs[4]  = mkv(0,0,1,0,0, 0,0,0,0, 2'd1, 32'd1, 16'd0);  // load-use freeze
    vecs[5]  = mkv(0,0,0,0,0, 1,0,1,0, 2'd1, 32'd1, 16'd1);
    vecs[6]  = mkv(0,1,1,0,0, 1,1,1,1, 2'd1, 32'd2, 16'd1);  // branch squashes load-use
    vecs[7]  = mkv(0,0,0,0,0, 1,0,1,0, 2'd1, 32'd2, 16'd1);
    vecs[8]  = mkv(0,0,0,1,0, 1,0,1,0, 2'd1, 32'd3, 16'd1);  // halt request
    vecs[9]  = mkv(0,0,0,0,0, 0,0,0,1, 2'd3, 32'd4, 16'd1);  // halted 1
    vecs[10] = mkv(0,1,1,0,0, 0,0,0,1, 2'd3, 32'd4, 16'd1);  // halted 2, events ignored
    vecs[11] = mkv(0,0,1,0,0, 0,0,0,1, 2'd3, 32'd4, 16'd1);  // halted 3
    vecs[12] = mkv(0,0,0,0,0, 0,0,0,1, 2'd3, 32'd4, 16'd1);  // halted 4
    vecs[13] = mkv(0,0,0,1,1, 0,0,0,1, 2'd3, 32'd4, 16'd1);  // halted 5, resume wins
    vecs[14] = mkv(0,0,0,0,0, 1,0,1,0, 2'd1, 32'd4, 16'd1);
    vecs[15] = mkv(0,1,0,1,0, 1,1,1,1, 2'd1, 32'd5, 16'd1);  // branch + halt
    vecs[16] = mkv(0,0,0,0,1, 0,0,0,1, 2'd3, 32'd5, 16'd1);
    vecs[17] = mkv(0,0,1,1,0, 1,0,1,0, 2'd1, 32'd5, 16'd1);  // halt beats load-use
    vecs[18] = mkv(0,0,0,0,1, 0,0,0,1, 2'd3, 32'd6, 16'd1);
    vecs[19] = mkv(0,0,0,0,0, 1,0,1,0, 2'd1, 32'd6, 16'd1);

    reset_s = 1'b1; br_s = 1'b0; lu_s = 1'b0; hr_s = 1'b0; rs_s = 1'b0;
    m1 = mdl_reset();
    m3 = mdl_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].r, vecs[i].b, vecs[i].l, vecs[i].h, vecs[i].q);
      chk("tbl.pc_write_en",    32'(d1_pwe),  32'(vecs[i].pwe));
      chk("tbl.pc_sel",         32'(d1_sel),  32'(vecs[i].sel));
      chk("tbl.if_id_write_en", 32'(d1_ifwe), 32'(vecs[i].ifwe));
      chk("tbl.if_id_flush",    32'(d1_fl),   32'(vecs[i].fl));
      chk("tbl.state",          32'(d1_st),   32'(vecs[i].st));
      chk("tbl.fetch_count",    d1_fc,        vecs[i].fc);
      chk("tbl.stall_count",    32'(d1_sc),   32'(vecs[i].sc));
      advance();
    end

    // Watchdog: load_use held 20 cycles from a fresh RUN on dut1.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    for (int i = 0; i < BOOT; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    end
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k <= 16) chk("wd.frozen_pwe", 32'(d1_pwe), 32'd0);
      if (k == 16) begin
        chk("wd.tmo_before", 32'(d1_tmo), 32'd0);
        chk("wd.sc_before",  32'(d1_sc),  32'd15);
      end
      if (k == 17) begin
        chk("wd.forced_pwe", 32'(d1_pwe), 32'd1);
        chk("wd.tmo_set",    32'(d1_tmo), 32'd1);
        chk("wd.sc_at16",    32'(d1_sc),  32'd16);
      end
      if (k >= 18) chk("wd.refreeze_pwe", 32'(d1_pwe), 32'd0);
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd.sc_final",  32'(d1_sc),  32'd19);
    chk("wd.tmo_stick", 32'(d1_tmo), 32'd1);
    advance();

    // Reset in the second STALL cycle of a three-cycle stall (dut3).
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    for (int i = 0; i < BOOT + 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst.run_freeze", 32'(d3_pwe), 32'd0);
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.stall1_state", 32'(d3_st), 32'd2);
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.stall2_state", 32'(d3_st), 32'd2);
    chk("rst.stall2_sc",    32'(d3_sc), 32'd2);
    chk("rst.stall2_fc",    d3_fc,      32'd3);
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.state", 32'(d3_st),  32'd0);
    chk("rst.fc",    d3_fc,       32'd0);
    chk("rst.sc",    32'(d3_sc),  32'd0);
    chk("rst.tmo",   32'(d3_tmo), 32'd0);
    chk("rst.flush", 32'(d3_fl),  32'd1);
    advance();

    // Randomized traffic with occasional long load-use bursts.
    for (int i = 0; i < 4000; i++) begin
      logic r, b, l, h, q;
      if (burst == 0 && $urandom_range(99) < 2) burst = 18 + int'($urandom_range(6));
      if (burst > 0) begin
        burst--;
        r = 1'b0; b = 1'b0; l = 1'b1; q = 1'b0;
        h = ($urandom_range(99) < 3);
      end else begin
        r = ($urandom_range(299) == 0);
        b = ($urandom_range(99) < 12);
        l = ($urandom_range(99) < 35);
        h = ($urandom_range(99) < 6);
        q = ($urandom_range(99) < 25);
      end
      drive(r, b, l, h, q);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
